porta_ctrl_uart_tx: RTL
=======================

Name: porta_ctrl_uart_tx

Overview:
Controller-side serial transmitter for the portable. Periodically snapshots both joystick pads (player 1 and player 2 pins) and sends them as a fixed 4-byte UART packet on TX. The packet feeds the glue CPLD RX input, so the pads can sit behind a single wire instead of 14 parallel pins. Runs on the system clock (3.579545 MHz nominal).

Parameters:
BAUD_DIV, 31, clocks per UART bit (31 gives about 115.5 kbaud at 3.579545 MHz); legal values are 2 and above.
PKT_INTERVAL, 59659, clocks between packet-start requests (about 60 Hz); must be at least 4*10*BAUD_DIV.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
EN  input  1  1 enables the interval counter and packet starts.
C1P  input  7  player 1 pad pins, raw levels (0 = pressed): [0]P0 [1]P1 [2]P2 [3]P3 [4]P5 [5]P6 [6]P8.
C2P  input  7  player 2 pad pins, same mapping.
TX  output  1  UART line; idles high.
BUSY  output  1  1 from the start bit of byte 0 through the stop bit of byte 3.
FRAME_DONE  output  1  one-clock pulse in the last clock of byte 3's stop bit.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: TX=1, BUSY=0, FRAME_DONE=0, state IDLE. Interval counter, baud counter, bit index, byte index, pending request and snapshot all clear to 0. Sync flops reset to 1.
- rst asserted mid-packet aborts the packet. TX is 1 after that edge, and no partial-packet resume occurs.
- Input sync: C1P and C2P each pass through 2 flops. The snapshot uses only the synced values.
- Interval counter:
  - Counts 0..PKT_INTERVAL-1 while EN=1, then wraps. It is held at 0 while EN=0.
  - When it equals PKT_INTERVAL-1, a start request is raised.
  - If the FSM is IDLE, the packet starts on the next edge. Otherwise a single pending flag is set (requests do not queue beyond one).
  - The pending flag is served on the edge after the FSM returns to IDLE, if EN=1. It is cleared when EN=0.
- First packet: TX falls exactly PKT_INTERVAL clocks after rst release, with EN held at 1.
- Snapshot: latched on the packet-start edge and held constant for the whole packet. Pin changes during a packet appear only in the next packet.
- Packet bytes, sent in order:
  - B0 = 0xA5
  - B1 = {1'b0, C1P}
  - B2 = {1'b0, C2P}
  - B3 = B0 ^ B1 ^ B2
- Frame format: 8N1, LSB first: start bit 0, data bits 0..7, stop bit 1. Each bit lasts exactly BAUD_DIV clocks.
- Byte n+1's start bit directly follows byte n's stop bit, with no idle gap. A packet lasts 40*BAUD_DIV clocks.
- FSM: IDLE -> START -> DATA (8 bits) -> STOP. From STOP it goes to START if byte index < 3, otherwise to IDLE.
- BUSY=0 only in IDLE. FRAME_DONE is asserted on the final STOP clock, concurrent with BUSY=1.
- EN=0 mid-packet: the current packet completes normally, and no new start follows.

Optional Feature:
PORTA_CTRL_UART_PARITY_EN:
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between data bit 7 and the stop bit. Frames become 11 bits and packets last 44*BAUD_DIV clocks. The minimum PKT_INTERVAL becomes 44*BAUD_DIV.
- Undefined: 8N1 exactly as above, and no parity logic is synthesized.

Test Plan:
1. Reset: rst=1 for 4 clocks with random pins and EN=1 -> TX=1, BUSY=0, FRAME_DONE=0 throughout, and one clock after release.
2. Packet content (BAUD_DIV=4, PKT_INTERVAL=200, C1P=7'h7F, C2P=7'h7E, EN=1):
   - TX falls 200 clocks after rst release.
   - Decoded bytes are A5, 7F, 7E, A4, with each bit 4 clocks wide.
   - BUSY=1 for 160 clocks; FRAME_DONE pulses once, in clock 160.
3. Snapshot hold: change C1P from 7F to 7C during B1's bit 3 -> the current packet sends 7F with checksum A4. The next packet sends 7C with checksum A5^7C^7E = A7.
4. EN drop: deassert EN during B2 -> the packet completes with a FRAME_DONE pulse and no further TX activity for 1000 clocks. Reassert EN -> TX falls 200 clocks later.
5. Reset mid-byte: assert rst for 1 clock during B1 data -> TX=1 and BUSY=0 on the next edge. The next packet starts 200 clocks after release and carries complete, correct bytes.
6. Parity (macro defined, same values as scenario 2):
   - Frames are 11 bits (44 clocks each).
   - Parity bits are A5->0, 7F->1, 7E->0, A4->1.
   - BUSY lasts 176 clocks.

Source files
------------

// File: rtl/porta_ctrl_uart_tx.sv
// porta_ctrl_uart_tx
// Snapshots both joystick pads at a fixed interval and sends them as a
// 4-byte UART packet: A5, {0,C1P}, {0,C2P}, checksum (XOR of the first three).
// Frames are 8N1, LSB first, BAUD_DIV clocks per bit, bytes back to back.
// Optional build macro PORTA_CTRL_UART_PARITY_EN inserts an even-parity bit
// between data bit 7 and the stop bit (11-bit frames).
module porta_ctrl_uart_tx #(
  parameter int BAUD_DIV     = 31,
  parameter int PKT_INTERVAL = 59659
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EN,
  input  logic [6:0] C1P,
  input  logic [6:0] C2P,
  output logic       TX,
  output logic       BUSY,
  output logic       FRAME_DONE
);

  localparam int CNT_W  = $clog2(PKT_INTERVAL);
  localparam int BAUD_W = $clog2(BAUD_DIV);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
`ifdef PORTA_CTRL_UART_PARITY_EN
  localparam logic [2:0] ST_PAR   = 3'd4;
`endif

  // Packet byte selected by index from the latched pad snapshot
  // (snap[6:0] = player 1, snap[13:7] = player 2).
  function automatic logic [7:0] pkt_byte(input logic [1:0] idx, input logic [13:0] snap);
    logic [7:0] b1;
    logic [7:0] b2;
    b1 = {1'b0, snap[6:0]};
    b2 = {1'b0, snap[13:7]};
    case (idx)
      2'd0:    pkt_byte = 8'hA5;
      2'd1:    pkt_byte = b1;
      2'd2:    pkt_byte = b2;
      default: pkt_byte = 8'hA5 ^ b1 ^ b2;
    endcase
  endfunction

  logic [6:0]        c1_s1_q, c1_s2_q, c2_s1_q, c2_s2_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [1:0]        byte_q, byte_d;
  logic              pend_q, pend_d;
  logic [13:0]       snap_q, snap_d;
  logic              tx_q, tx_d;
  logic              req;
  logic              bit_end;
  logic              start_now;
  logic [7:0]        cur_byte;

  // Two-flop synchronizers for the raw pad pins (idle level is high).
  always_ff @(posedge clk) begin
    if (rst) begin
      c1_s1_q <= '1;
      c1_s2_q <= '1;
      c2_s1_q <= '1;
      c2_s2_q <= '1;
    end else begin
      c1_s1_q <= C1P;
      c1_s2_q <= c1_s1_q;
      c2_s1_q <= C2P;
      c2_s2_q <= c2_s1_q;
    end
  end

  assign req       = EN && (cnt_q == CNT_W'(PKT_INTERVAL - 1));
  assign bit_end   = (baud_q == BAUD_W'(BAUD_DIV - 1));
  assign start_now = (state_q == ST_IDLE) && EN && (req || pend_q);

  // Free-running interval counter, parked at zero while disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (!EN)
      cnt_d = '0;
    else if (cnt_q == CNT_W'(PKT_INTERVAL - 1))
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;
  end

  // Single-entry pending request: set when a request lands mid-packet,
  // dropped when served from IDLE or when the interface is disabled.
  always_comb begin
    pend_d = pend_q;
    if (!EN)
      pend_d = 1'b0;
    else if (req && (state_q != ST_IDLE))
      pend_d = 1'b1;
    else if (state_q == ST_IDLE)
      pend_d = 1'b0;
  end

  // Transmit FSM next state and the registered line level for that state.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    snap_d   = snap_q;
    cur_byte = 8'h00;
    tx_d     = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start_now) begin
          state_d = ST_START;
          baud_d  = '0;
          bit_d   = 3'd0;
          byte_d  = 2'd0;
          snap_d  = {c2_s2_q, c1_s2_q};
        end
      end
      ST_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef PORTA_CTRL_UART_PARITY_EN
            state_d = ST_PAR;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef PORTA_CTRL_UART_PARITY_EN
      ST_PAR: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (byte_q == 2'd3) begin
            state_d = ST_IDLE;
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = ST_START;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cur_byte = pkt_byte(byte_d, snap_d);
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = cur_byte[bit_d];
`ifdef PORTA_CTRL_UART_PARITY_EN
      ST_PAR:   tx_d = ^cur_byte;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // Control and datapath registers; reset aborts any packet in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      pend_q  <= 1'b0;
      snap_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      pend_q  <= pend_d;
      snap_q  <= snap_d;
      tx_q    <= tx_d;
    end
  end

  assign TX         = tx_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign FRAME_DONE = (state_q == ST_STOP) && (byte_q == 2'd3) && bit_end;

endmodule
